// File: rtl/cocosketch_sched.sv
// Issue-slot scheduler for the CocoSketch pipeline: round-robin insert/query arbitration plus epoch clear sweeps.
// Registered issue one cycle after handshake; downstream never stalls, requesters wait via ready while draining/clearing.
module cocosketch_sched #(
   parameter int RAM_PTR   = 4,
   parameter int PIPE_LAT  = 8,
   parameter int EPOCH_LEN = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [63:0]        ins_e_f,
   input  logic               ins_valid,
   output logic               ins_ready,
   input  logic [63:0]        qry_key,
   input  logic               qry_valid,
   output logic               qry_ready,
   input  logic               clr_req,
   output logic [63:0]        out_e_f,
   output logic               out_valid,
   output logic [1:0]         out_op,
   output logic [RAM_PTR-1:0] out_addr,
   output logic               busy,
   output logic [15:0]        epoch_cnt
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

   localparam logic [1:0]       OP_INS     = 2'b00;
   localparam logic [1:0]       OP_QRY     = 2'b01;
   localparam logic [1:0]       OP_CLR     = 2'b10;
   localparam logic [15:0]      DRAIN_INIT = 16'(PIPE_LAT);
   localparam logic [15:0]      EPOCH_L    = 16'(EPOCH_LEN);
   localparam logic [RAM_PTR:0] SWEEP_LAST = (RAM_PTR+1)'((1 << RAM_PTR) - 1);

   state_t               state_q, state_d;
   logic                 clr_pend_q, clr_pend_d;
   logic                 rr_last_q, rr_last_d;   // 1 = query was granted last
   logic [15:0]          ins_cnt_q, ins_cnt_d;
   logic [15:0]          drain_q, drain_d;
   logic [RAM_PTR:0]     sweep_q, sweep_d;
   logic [15:0]          epoch_q, epoch_d;
   logic                 out_valid_q, out_valid_d;
   logic [1:0]           out_op_q, out_op_d;
   logic [63:0]          out_e_f_q, out_e_f_d;
   logic [RAM_PTR-1:0]   out_addr_q, out_addr_d;
   logic                 can_grant;

   assign can_grant = (state_q == ST_RUN) && !clr_pend_q;
   assign ins_ready = can_grant && ins_valid && (!qry_valid || rr_last_q);
   assign qry_ready = can_grant && qry_valid && (!ins_valid || !rr_last_q);

   assign out_valid = out_valid_q;
   assign out_op    = out_op_q;
   assign out_e_f   = out_e_f_q;
   assign out_addr  = out_addr_q;
   assign busy      = (state_q != ST_RUN);
   assign epoch_cnt = epoch_q;

   always_comb begin
      state_d     = state_q;
      clr_pend_d  = clr_pend_q;
      rr_last_d   = rr_last_q;
      ins_cnt_d   = ins_cnt_q;
      drain_d     = drain_q;
      sweep_d     = sweep_q;
      epoch_d     = epoch_q;
      out_valid_d = 1'b0;
      out_op_d    = out_op_q;
      out_e_f_d   = out_e_f_q;
      out_addr_d  = out_addr_q;
      case (state_q)
         ST_RUN: begin
            if (clr_pend_q) begin
               state_d    = ST_DRAIN;
               drain_d    = DRAIN_INIT;
               clr_pend_d = 1'b0;
            end else begin
               if (ins_ready) begin
                  out_valid_d = 1'b1;
                  out_op_d    = OP_INS;
                  out_e_f_d   = ins_e_f;
                  out_addr_d  = '0;
                  rr_last_d   = 1'b0;
                  ins_cnt_d   = ins_cnt_q + 16'd1;
                  if (EPOCH_LEN != 0 && ins_cnt_d == EPOCH_L) clr_pend_d = 1'b1;
               end else if (qry_ready) begin
                  out_valid_d = 1'b1;
                  out_op_d    = OP_QRY;
                  out_e_f_d   = qry_key;
                  out_addr_d  = '0;
                  rr_last_d   = 1'b1;
               end
               if (clr_req) clr_pend_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Leave once the count would reach zero so the drain lasts exactly PIPE_LAT cycles.
            if (drain_q <= 16'd1) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
               drain_d = '0;
            end else begin
               drain_d = drain_q - 16'd1;
            end
         end
         ST_CLEAR: begin
            out_valid_d = 1'b1;
            out_op_d    = OP_CLR;
            out_e_f_d   = '0;
            out_addr_d  = sweep_q[RAM_PTR-1:0];
            sweep_d     = sweep_q + 1'b1;
            if (sweep_q == SWEEP_LAST) begin
               state_d   = ST_RUN;
               epoch_d   = epoch_q + 16'd1;
               ins_cnt_d = '0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         clr_pend_q  <= 1'b0;
         rr_last_q   <= 1'b1;
         ins_cnt_q   <= '0;
         drain_q     <= '0;
         sweep_q     <= '0;
         epoch_q     <= '0;
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_e_f_q   <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_pend_q  <= clr_pend_d;
         rr_last_q   <= rr_last_d;
         ins_cnt_q   <= ins_cnt_d;
         drain_q     <= drain_d;
         sweep_q     <= sweep_d;
         epoch_q     <= epoch_d;
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_e_f_q   <= out_e_f_d;
         out_addr_q  <= out_addr_d;
      end
   end

endmodule

// File: tb/tb_cocosketch_sched.sv
// Directed bench: default instance for arbitration/clear/reset, EPOCH_LEN=5 instance for auto-clear.
module tb_cocosketch_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] ins_e_f = '0, qry_key = '0;
   logic        ins_valid = 1'b0, qry_valid = 1'b0, clr_req = 1'b0;
   logic        ins_ready, qry_ready, out_valid, busy;
   logic [63:0] out_e_f;
   logic [1:0]  out_op;
   logic [3:0]  out_addr;
   logic [15:0] epoch_cnt;

   logic [63:0] a_ins_e_f = '0;
   logic        a_ins_valid = 1'b0;
   logic        a_qry_valid = 1'b0, a_clr_req = 1'b0;
   logic [63:0] a_qry_key = '0;
   logic        a_ins_ready, a_qry_ready, a_out_valid, a_busy;
   logic [63:0] a_out_e_f;
   logic [1:0]  a_out_op;
   logic [3:0]  a_out_addr;
   logic [15:0] a_epoch_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cocosketch_sched dut (
      .clk(clk), .rst_n(rst_n),
      .ins_e_f(ins_e_f), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .qry_key(qry_key), .qry_valid(qry_valid), .qry_ready(qry_ready),
      .clr_req(clr_req), .out_e_f(out_e_f), .out_valid(out_valid),
      .out_op(out_op), .out_addr(out_addr), .busy(busy), .epoch_cnt(epoch_cnt)
   );

   cocosketch_sched #(.RAM_PTR(4), .PIPE_LAT(8), .EPOCH_LEN(5)) u_auto (
      .clk(clk), .rst_n(rst_n),
      .ins_e_f(a_ins_e_f), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
      .qry_key(a_qry_key), .qry_valid(a_qry_valid), .qry_ready(a_qry_ready),
      .clr_req(a_clr_req), .out_e_f(a_out_e_f), .out_valid(a_out_valid),
      .out_op(a_out_op), .out_addr(a_out_addr), .busy(a_busy), .epoch_cnt(a_epoch_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_clr;
      int n_out;
      logic exp_ins, exp_clr;

      // Reset state
      ins_valid = 1'b1;
      ins_e_f   = 64'h1234;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_op", out_op, 0);
      chk("rst_out_e_f", out_e_f, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_epoch", epoch_cnt, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("first_ins_ready", ins_ready, 1);
      tick();
      ins_valid = 1'b0;
      #1;
      chk("first_out_valid", out_valid, 1);
      chk("first_out_op", out_op, 2'b00);
      chk("first_out_e_f", out_e_f, 64'h1234);

      // Lone query, leaving rr_last = query
      qry_valid = 1'b1;
      qry_key   = 64'hAAAA;
      #1 chk("lone_qry_ready", qry_ready, 1);
      tick();
      qry_valid = 1'b0;
      #1;
      chk("lone_qry_op", out_op, 2'b01);
      chk("lone_qry_e_f", out_e_f, 64'hAAAA);

      // Both requesters held high: alternate I,Q,I,Q,I,Q
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            ins_valid = 1'b1; qry_valid = 1'b1;
            ins_e_f = 64'h100 + 64'(i); qry_key = 64'h200 + 64'(i);
         end else begin
            ins_valid = 1'b0; qry_valid = 1'b0;
         end
         #1;
         if (i < 6) begin
            chk("rr_ins_ready", ins_ready, (i % 2 == 0));
            chk("rr_qry_ready", qry_ready, (i % 2 == 1));
         end
         if (i > 0) begin
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_op", out_op, ((i - 1) % 2 == 0) ? 2'b00 : 2'b01);
            chk("rr_out_e_f", out_e_f, ((i - 1) % 2 == 0) ? 64'h100 + 64'(i - 1) : 64'h200 + 64'(i - 1));
         end
         tick();
      end
      #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_hold_op", out_op, 2'b01);
      chk("idle_hold_e_f", out_e_f, 64'h205);

      // Software clear with an insert waiting throughout
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      ins_valid = 1'b1;
      ins_e_f = 64'h5555;
      for (int c = 1; c <= 27; c++) begin
         if (c == 27) ins_valid = 1'b0;
         #1;
         if (c <= 26) chk("clr_ins_ready", ins_ready, (c == 26));
         chk("clr_busy", busy, (c >= 2 && c <= 25));
         chk("clr_epoch", epoch_cnt, (c >= 26) ? 1 : 0);
         chk("clr_out_valid", out_valid, (c >= 11));
         if (c >= 11 && c <= 26) begin
            chk("clr_out_op", out_op, 2'b10);
            chk("clr_out_addr", out_addr, 64'(c - 11));
            chk("clr_out_e_f", out_e_f, 0);
         end
         if (c == 27) begin
            chk("resume_op", out_op, 2'b00);
            chk("resume_e_f", out_e_f, 64'h5555);
            chk("resume_addr", out_addr, 0);
         end
         tick();
      end

      // Extra clr_req pulses during DRAIN and CLEAR are ignored
      clr_req = 1'b1;
      tick();
      n_clr = 0;
      for (int c = 1; c <= 40; c++) begin
         clr_req = (c == 5 || c == 15);
         #1;
         if (out_valid && out_op == 2'b10) n_clr++;
         tick();
      end
      clr_req = 1'b0;
      chk("ign_clear_count", n_clr, 16);
      chk("ign_epoch", epoch_cnt, 2);
      chk("ign_busy", busy, 0);

      // Reset during sweep at address 7
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 1; c < 18; c++) tick();
      #1;
      chk("mid_addr_before", out_addr, 7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_addr", out_addr, 0);
      chk("mid_rst_op", out_op, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_epoch", epoch_cnt, 0);
      #1 rst_n = 1'b1;
      n_out = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         #1;
         if (out_valid) n_out++;
      end
      chk("mid_no_ops", n_out, 0);
      chk("mid_epoch_after", epoch_cnt, 0);
      ins_valid = 1'b1;
      #1 chk("mid_run_ready", ins_ready, 1);
      ins_valid = 1'b0;
      tick();

      // Auto clear every 5 inserts
      for (int c = 0; c <= 65; c++) begin
         a_ins_valid = 1'b1;
         a_ins_e_f = 64'h900 + 64'(c);
         #1;
         exp_ins = (c >= 1) && (((c - 1) % 30) <= 4);
         exp_clr = (c >= 15) && (((c - 15) % 30) <= 15);
         chk("auto_ready", a_ins_ready, ((c % 30) <= 4));
         chk("auto_out_valid", a_out_valid, exp_ins || exp_clr);
         if (exp_ins) begin
            chk("auto_ins_op", a_out_op, 2'b00);
            chk("auto_ins_e_f", a_out_e_f, 64'h900 + 64'(c - 1));
         end
         if (exp_clr) chk("auto_clr_op", a_out_op, 2'b10);
         chk("auto_epoch", a_epoch_cnt, (c >= 60) ? 2 : ((c >= 30) ? 1 : 0));
         tick();
      end
      a_ins_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
